fetch_stage: RTL and testbench

//  Instruction-fetch stage and IF/ID pipeline register feeding the decode/control stage.

---
 rtl/fetch_stage.sv | 180 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage plus the IF/ID pipeline register.
//   Keeps the PC and fetches from instruction memory over a req/ready
//   handshake. Branches and JR jumps redirect the PC. A one-entry hold
//   buffer absorbs a fetch that completes while decode is stalled. A fetch
//   left in flight by a redirect is drained and its data is discarded.
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   stall                         hold IF/ID and PC (hazard unit)
//   branch_taken, branch_target   taken branch and its destination
//   jump                          00 none, 01 JR reg value, 10 JR fwd value
//   jr_reg_value, jr_fwd_value    JR destinations (register file / forwarded)
//   imem_req, imem_addr           fetch request and word-aligned address
//   imem_ready, imem_rdata        completion strobe and fetched instruction
//   if_id_instr, if_id_pc_plus4,
//   if_id_valid                   IF/ID register toward decode
//   pc_out                        current PC register (debug)
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [1:0]  jump,
    input  logic [31:0] jr_reg_value,
    input  logic [31:0] jr_fwd_value,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic [31:0] pc_out
);

    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic [1:0]  state_q,         state_d;
    logic [31:0] pc_q,            pc_d;
    logic [31:0] redirect_pc_q,   redirect_pc_d;
    logic [31:0] hold_instr_q,    hold_instr_d;
    logic [31:0] hold_pc4_q,      hold_pc4_d;
    logic [31:0] if_id_instr_q,   if_id_instr_d;
    logic [31:0] if_id_pc4_q,     if_id_pc4_d;
    logic        if_id_valid_q,   if_id_valid_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    // Jump outranks branch; the forwarded JR value outranks the RF value.
    always_comb begin
        redirect = (jump == 2'b01) || (jump == 2'b10) || branch_taken;
        if (jump == 2'b10)
            target = jr_fwd_value;
        else if (jump == 2'b01)
            target = jr_reg_value;
        else
            target = branch_target;
    end

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redirect_pc_d = redirect_pc_q;
        hold_instr_d  = hold_instr_q;
        hold_pc4_d    = hold_pc4_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_valid_d = if_id_valid_q;

        case (state_q)
            ST_FETCH: begin
                if (redirect) begin
                    if_id_instr_d = NOP_INSTR;
                    if_id_pc4_d   = 32'd0;
                    if_id_valid_d = 1'b0;
                    if (imem_ready) begin
                        pc_d = target;
                    end else begin
                        // Request still outstanding: it must finish at its
                        // old address before the new PC can be issued.
                        redirect_pc_d = target;
                        state_d       = ST_DISCARD;
                    end
                end else if (imem_ready) begin
                    if (stall) begin
                        hold_instr_d = imem_rdata;
                        hold_pc4_d   = pc_plus4;
                        state_d      = ST_HOLD;
                    end else begin
                        if_id_instr_d = imem_rdata;
                        if_id_pc4_d   = pc_plus4;
                        if_id_valid_d = 1'b1;
                        pc_d          = pc_plus4;
                    end
                end else if (!stall) begin
                    // Waiting on memory with decode free: feed a bubble.
                    if_id_instr_d = NOP_INSTR;
                    if_id_pc4_d   = 32'd0;
                    if_id_valid_d = 1'b0;
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    if_id_instr_d = NOP_INSTR;
                    if_id_pc4_d   = 32'd0;
                    if_id_valid_d = 1'b0;
                    pc_d          = target;
                    state_d       = ST_FETCH;
                end else if (!stall) begin
                    if_id_instr_d = hold_instr_q;
                    if_id_pc4_d   = hold_pc4_q;
                    if_id_valid_d = 1'b1;
                    pc_d          = hold_pc4_q;
                    state_d       = ST_FETCH;
                end
            end

            ST_DISCARD: begin
                if_id_instr_d = NOP_INSTR;
                if_id_pc4_d   = 32'd0;
                if_id_valid_d = 1'b0;
                if (redirect)
                    redirect_pc_d = target;
                if (imem_ready) begin
                    // Latest redirect wins, including one in this cycle.
                    pc_d    = redirect ? target : redirect_pc_q;
                    state_d = ST_FETCH;
                end
            end

            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            redirect_pc_q <= 32'd0;
            hold_instr_q  <= 32'd0;
            hold_pc4_q    <= 32'd0;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc4_q   <= 32'd0;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redirect_pc_q <= redirect_pc_d;
            hold_instr_q  <= hold_instr_d;
            hold_pc4_q    <= hold_pc4_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    // DISCARD keeps requesting at the unchanged PC, so the address stays
    // stable until the abandoned fetch is acknowledged.
    assign imem_req       = rst_n && (state_q != ST_HOLD);
    assign imem_addr      = {pc_q[31:2], 2'b00};
    assign if_id_instr    = if_id_instr_q;
    assign if_id_pc_plus4 = if_id_pc4_q;
    assign if_id_valid    = if_id_valid_q;
    assign pc_out         = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst_n, stall, branch_taken, imem_ready;
    logic [1:0]  jump;
    logic [31:0] branch_target, jr_reg_value, jr_fwd_value;
    logic        imem_req, if_id_valid;
    logic [31:0] imem_addr, imem_rdata, if_id_instr, if_id_pc_plus4, pc_out;
    logic        imem_req2, if_id_valid2;
    logic [31:0] imem_addr2, imem_rdata2, if_id_instr2, if_id_pc_plus42, pc_out2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign imem_rdata  = mem_word(imem_addr);
    assign imem_rdata2 = mem_word(imem_addr2);

    fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jr_reg_value(jr_reg_value), .jr_fwd_value(jr_fwd_value),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid(if_id_valid), .pc_out(pc_out));

    fetch_stage #(.RESET_PC(WRAP_PC), .NOP_INSTR(NOP)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jr_reg_value(jr_reg_value), .jr_fwd_value(jr_fwd_value),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata2),
        .if_id_instr(if_id_instr2), .if_id_pc_plus4(if_id_pc_plus42),
        .if_id_valid(if_id_valid2), .pc_out(pc_out2));

    // ---------------- reference model (for dut, RESET_PC=0) ----------------
    // The fetch unit is viewed as: a PC, an optional parked instruction
    // waiting for decode, and an optional "wrong path" fetch still in flight.
    logic [31:0] m_pc, m_instr, m_pc4, m_wrong_dest;
    logic        m_valid, m_wrong;
    logic [63:0] m_parked[$];

    function automatic logic exp_req();
        return rst_n && (m_parked.size() == 0);
    endfunction

    task automatic model_flush();
        m_instr = NOP; m_pc4 = 32'd0; m_valid = 1'b0;
    endtask

    task automatic model_update();
        logic [31:0] dest;
        logic        redir;
        logic [63:0] e;
        if (!rst_n) begin
            m_pc = 32'h0; m_parked.delete(); m_wrong = 1'b0; m_wrong_dest = 32'h0;
            model_flush();
            return;
        end
        redir = branch_taken || jump == 2'b01 || jump == 2'b10;
        dest  = (jump == 2'b10) ? jr_fwd_value :
                (jump == 2'b01) ? jr_reg_value : branch_target;
        if (m_parked.size() != 0) begin
            if (redir) begin
                void'(m_parked.pop_front()); model_flush(); m_pc = dest;
            end else if (!stall) begin
                e = m_parked.pop_front();
                m_instr = e[63:32]; m_pc4 = e[31:0]; m_valid = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end else if (m_wrong) begin
            model_flush();
            if (redir) m_wrong_dest = dest;
            if (imem_ready) begin m_pc = m_wrong_dest; m_wrong = 1'b0; end
        end else if (redir) begin
            model_flush();
            if (imem_ready) m_pc = dest;
            else begin m_wrong = 1'b1; m_wrong_dest = dest; end
        end else if (imem_ready) begin
            if (stall) m_parked.push_back({mem_word(m_pc & ~32'd3), m_pc + 32'd4});
            else begin
                m_instr = mem_word(m_pc & ~32'd3); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end else if (!stall) begin
            model_flush();
        end
    endtask

    // Model advances with the inputs seen at the edge; outputs sampled 1ns later.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; branch_taken = 0; jump = 2'b00; imem_ready = 1;
        branch_target = 0; jr_reg_value = 0; jr_fwd_value = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; idle_inputs();
        step(); step();
        rst_n = 1;
    endtask

    // ------------------------------ tests ------------------------------
    task automatic test_reset();
        rst_n = 0; idle_inputs();
        step(); step();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b want=0", imem_req); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", if_id_valid); end
        total++; if (if_id_instr !== NOP) begin bad++; $display("FAIL reset_instr got=%h want=%h", if_id_instr, NOP); end
        total++; if (if_id_pc_plus4 !== 32'h0) begin bad++; $display("FAIL reset_pc4 got=%h want=0", if_id_pc_plus4); end
        total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", pc_out); end
        rst_n = 1;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            bad++; $display("FAIL reset_first_fetch got req=%0b addr=%h want req=1 addr=0", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            step();
            total++; if (imem_addr !== 32'(4 * k)) begin bad++; $display("FAIL seq_addr k=%0d got=%h want=%h", k, imem_addr, 4 * k); end
            total++; if (if_id_valid !== 1'b1 || if_id_pc_plus4 !== 32'(4 * k) ||
                         if_id_instr !== mem_word(32'(4 * (k - 1)))) begin
                bad++; $display("FAIL seq_ifid k=%0d got v=%0b pc4=%h ins=%h want pc4=%h ins=%h",
                                k, if_id_valid, if_id_pc_plus4, if_id_instr, 4 * k, mem_word(32'(4 * (k - 1))));
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] p, frz_instr, frz_pc4;
        do_reset();
        step(); step();
        p = imem_addr; frz_instr = if_id_instr; frz_pc4 = if_id_pc_plus4;
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req k=%0d got=%0b want=0", k, imem_req); end
            total++; if (if_id_instr !== frz_instr || if_id_pc_plus4 !== frz_pc4 || if_id_valid !== 1'b1) begin
                bad++; $display("FAIL stall_frozen k=%0d got ins=%h pc4=%h want ins=%h pc4=%h", k, if_id_instr, if_id_pc_plus4, frz_instr, frz_pc4);
            end
        end
        stall = 0;
        step();
        total++; if (if_id_valid !== 1'b1 || if_id_instr !== mem_word(p) || if_id_pc_plus4 !== p + 4) begin
            bad++; $display("FAIL stall_release got v=%0b ins=%h pc4=%h want ins=%h pc4=%h", if_id_valid, if_id_instr, if_id_pc_plus4, mem_word(p), p + 4);
        end
        total++; if (imem_req !== 1'b1 || imem_addr !== p + 4) begin
            bad++; $display("FAIL stall_next_addr got req=%0b addr=%h want %h", imem_req, imem_addr, p + 4);
        end
        step();
        total++; if (if_id_instr !== mem_word(p + 4) || if_id_pc_plus4 !== p + 8) begin
            bad++; $display("FAIL stall_order got ins=%h pc4=%h want ins=%h pc4=%h", if_id_instr, if_id_pc_plus4, mem_word(p + 4), p + 8);
        end
    endtask

    task automatic test_discard();
        logic [31:0] p;
        do_reset();
        step(); step();
        p = imem_addr;
        imem_ready = 0; branch_taken = 1; branch_target = 32'h100;
        step();
        branch_taken = 0;
        for (int k = 0; k < 2; k++) begin
            total++; if (imem_req !== 1'b1 || imem_addr !== p || if_id_valid !== 1'b0) begin
                bad++; $display("FAIL discard_wait k=%0d got req=%0b addr=%h v=%0b want addr=%h v=0", k, imem_req, imem_addr, if_id_valid, p);
            end
            step();
        end
        imem_ready = 1;
        step();
        total++; if (imem_addr !== 32'h100 || if_id_valid !== 1'b0) begin
            bad++; $display("FAIL discard_redirect got addr=%h v=%0b want addr=100 v=0", imem_addr, if_id_valid);
        end
        step();
        total++; if (if_id_valid !== 1'b1 || if_id_instr !== mem_word(32'h100) || if_id_pc_plus4 !== 32'h104) begin
            bad++; $display("FAIL discard_target_data got v=%0b ins=%h pc4=%h want ins=%h pc4=104", if_id_valid, if_id_instr, if_id_pc_plus4, mem_word(32'h100));
        end
    endtask

    task automatic test_jump_priority();
        do_reset();
        step();
        jump = 2'b10; jr_fwd_value = 32'h40; jr_reg_value = 32'h80;
        branch_taken = 1; branch_target = 32'h200; stall = 1;
        step();
        total++; if (imem_addr !== 32'h40 || if_id_valid !== 1'b0) begin
            bad++; $display("FAIL jump_fwd got addr=%h v=%0b want addr=40 v=0", imem_addr, if_id_valid);
        end
        jump = 2'b01;
        step();
        total++; if (imem_addr !== 32'h80) begin bad++; $display("FAIL jump_reg got addr=%h want 80", imem_addr); end
        jump = 2'b11;
        step();
        total++; if (imem_addr !== 32'h200) begin bad++; $display("FAIL jump_reserved_branch got addr=%h want 200", imem_addr); end
        idle_inputs();
    endtask

    task automatic test_wrap();
        do_reset();
        #1;
        total++; if (imem_addr2 !== WRAP_PC) begin bad++; $display("FAIL wrap_first got=%h want=%h", imem_addr2, WRAP_PC); end
        step();
        total++; if (imem_addr2 !== 32'h0 || if_id_pc_plus42 !== 32'h0 || if_id_valid2 !== 1'b1 ||
                     if_id_instr2 !== mem_word(WRAP_PC)) begin
            bad++; $display("FAIL wrap_second got addr=%h pc4=%h v=%0b want addr=0 pc4=0 v=1", imem_addr2, if_id_pc_plus42, if_id_valid2);
        end
    endtask

    task automatic test_reset_mid_discard();
        do_reset();
        step(); step();
        imem_ready = 0; branch_taken = 1; branch_target = 32'h300;
        step();
        branch_taken = 0;
        rst_n = 0;
        step();
        total++; if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || pc_out !== 32'h0) begin
            bad++; $display("FAIL rst_discard got req=%0b v=%0b pc=%h want 0/0/0", imem_req, if_id_valid, pc_out);
        end
        rst_n = 1; imem_ready = 1;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            bad++; $display("FAIL rst_restart got req=%0b addr=%h want 1/0", imem_req, imem_addr);
        end
        step();
        total++; if (if_id_valid !== 1'b1 || if_id_pc_plus4 !== 32'h4 || imem_addr !== 32'h4) begin
            bad++; $display("FAIL rst_restart_seq got v=%0b pc4=%h addr=%h want 1/4/4", if_id_valid, if_id_pc_plus4, imem_addr);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 9) == 0);
            jump          = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            imem_ready    = ($urandom_range(0, 9) < 7);
            branch_target = $urandom & 32'h0000_0FFF;
            jr_reg_value  = $urandom;
            jr_fwd_value  = $urandom & 32'hFFFF_FFFC;
            rst_n         = ($urandom_range(0, 99) != 0);
            step();
            total++;
            if (imem_req !== exp_req() || (exp_req() && imem_addr !== (m_pc & ~32'd3)) ||
                pc_out !== m_pc || if_id_valid !== m_valid || if_id_instr !== m_instr ||
                (m_valid && if_id_pc_plus4 !== m_pc4)) begin
                bad++;
                $display("FAIL random n=%0d got req=%0b addr=%h pc=%h v=%0b ins=%h pc4=%h want req=%0b pc=%h v=%0b ins=%h pc4=%h",
                         n, imem_req, imem_addr, pc_out, if_id_valid, if_id_instr, if_id_pc_plus4,
                         exp_req(), m_pc, m_valid, m_instr, m_pc4);
            end
        end
        idle_inputs(); rst_n = 1;
    endtask

    initial begin
        rst_n = 0; idle_inputs();
        m_pc = 0; m_instr = NOP; m_pc4 = 0; m_valid = 0; m_wrong = 0; m_wrong_dest = 0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall();
        test_discard();
        test_jump_priority();
        test_wrap();
        test_reset_mid_discard();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
